smc_mem_resp_lite1: RTL
=======================

SMC_MEM_RESP_LITE1 -- requirements
Module: smc_mem_resp_lite1

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, meaning word-address bits decoded; storage depth = 2**ADDR_W words of 32 bits.
REQ-002 SHALL provide parameter RD_LAT_W, default 2, meaning width of the read-latency config input.
REQ-003 SHALL provide port sys_clk1  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL provide port n_sys_reset1  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port smc_n_cs1  input  1  chip select from the controller, active low.
REQ-006 SHALL provide port smc_n_oe1  input  1  read strobe, active low.
REQ-007 SHALL provide port smc_n_we1  input  4  per-byte write strobes, active low; bit i covers data[8i+7:8i].
REQ-008 SHALL provide port smc_addr1  input  ADDR_W  word address.
REQ-009 SHALL provide port smc_wdata1  input  32  write data driven by the controller.
REQ-010 SHALL provide port rd_latency1  input  RD_LAT_W  wait cycles before read data is valid; static during an access.
REQ-011 SHALL provide port smc_rdata1  output  32  read data returned to the controller.
REQ-012 SHALL provide port rd_valid1  output  1  high while smc_rdata1 carries valid data.
REQ-013 SHALL provide port wr_done1  output  1  one-cycle pulse when a write commits.
REQ-014 SHALL provide port proto_err1  output  1  one-cycle pulse on a protocol violation.
REQ-015 SHALL provide port wr_count1  output  8  count of committed writes.

Function
REQ-016 SHALL implement states IDLE, SEL, RD_WAIT, RD_DRV, WR, all strobes sampled as registered synchronous inputs.
REQ-017 IDLE: smc_n_cs1 low -> SEL; otherwise stay; strobes ignored while smc_n_cs1 high.
REQ-018 SEL: smc_n_cs1 high -> IDLE; smc_n_oe1 low and smc_n_we1 == 4'hF -> RD_WAIT with latency counter loaded from rd_latency1; smc_n_oe1 high and any smc_n_we1 bit low -> WR; else stay.
REQ-019 SEL, RD_WAIT, RD_DRV or WR with smc_n_oe1 low and any smc_n_we1 bit low in the same cycle: proto_err1 pulses, state -> SEL, no memory update, and any accumulated write is discarded.
REQ-020 RD_WAIT: counter decrements each cycle; on the cycle the counter is 0 -> RD_DRV; rd_latency1 == 0 gives RD_DRV on the cycle after SEL.
REQ-021 RD_WAIT abort: smc_n_oe1 high -> SEL, smc_n_cs1 high -> IDLE; no data driven, no error.
REQ-022 RD_DRV: rd_valid1 = 1, smc_rdata1 = mem[smc_addr1] registered each cycle, so an address change is reflected one cycle later.
REQ-023 RD_DRV exit: smc_n_oe1 high -> SEL; smc_n_cs1 high -> IDLE; rd_valid1 drops in the same cycle the state leaves.
REQ-024 Outside RD_DRV smc_rdata1 SHALL be 32'h0 and rd_valid1 SHALL be 0.
REQ-025 WR: each cycle, for every byte lane with strobe low, capture the address, that lane's data into a hold register, and set the lane's bit in an accumulated byte-enable mask (OR-accumulated).
REQ-026 WR exit on smc_n_we1 == 4'hF (-> SEL) or smc_n_cs1 high (-> IDLE): write the masked lanes of the hold register to mem[captured address], pulse wr_done1, increment wr_count1 (wraps 8'hFF -> 8'h00), clear the mask.
REQ-027 A back-to-back access without smc_n_cs1 deasserting SHALL pass through SEL; each access is independent.
REQ-028 Address bits beyond ADDR_W do not exist; there is no out-of-range case.

Reset
REQ-029 On n_sys_reset1 low: state IDLE; smc_rdata1 = 0; rd_valid1 = 0; wr_done1 = 0; proto_err1 = 0; wr_count1 = 0; byte-enable mask, hold register and all memory words = 0.
REQ-030 Reset asserted mid-write SHALL discard the write: no commit, no wr_done1.
REQ-031 First state transition SHALL occur no earlier than the second rising edge after reset release.

Verification
REQ-032 Write addr 3, data 32'hA5A5_1234, n_we = 4'h0 for 2 cycles, then 4'hF -> single wr_done1 pulse, wr_count1 = 1; subsequent read of addr 3 returns 32'hA5A5_1234.
REQ-033 rd_latency1 = 2, read addr 3 with n_oe held low -> rd_valid1 rises 3 cycles after SEL; smc_rdata1 = 32'hA5A5_1234 while valid; 0 after n_oe rises.
REQ-034 Write addr 5: n_we = 4'hE with data 32'h0000_00AA, then 4'h7 with data 32'hBB00_0000, then 4'hF -> mem[5] = 32'hBB00_00AA, one commit.
REQ-035 n_oe low and n_we = 4'hE together inside a write -> proto_err1 one cycle, memory unchanged, wr_count1 unchanged.
REQ-036 256 consecutive writes -> wr_count1 wraps to 8'h00; reset asserted during WR state -> all outputs 0, target word unchanged at 0.
REQ-037 rd_latency1 = 3, n_cs rises during RD_WAIT -> state IDLE, rd_valid1 never asserts, proto_err1 stays 0.

Source files
------------

// File: rtl/smc_mem_resp_lite1.sv
// Memory responder for the static memory controller: registered strobe sampling,
// programmable read latency, byte-lane write accumulation and protocol-error detection.
module smc_mem_resp_lite1 #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RD_LAT_W = 2
) (
  input  logic                sys_clk1,
  input  logic                n_sys_reset1,
  input  logic                smc_n_cs1,
  input  logic                smc_n_oe1,
  input  logic [3:0]          smc_n_we1,
  input  logic [ADDR_W-1:0]   smc_addr1,
  input  logic [31:0]         smc_wdata1,
  input  logic [RD_LAT_W-1:0] rd_latency1,
  output logic [31:0]         smc_rdata1,
  output logic                rd_valid1,
  output logic                wr_done1,
  output logic                proto_err1,
  output logic [7:0]          wr_count1
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, SEL, RD_WAIT, RD_DRV, WR} state_t;

  state_t                state_q;
  logic                  cs_n_q;
  logic                  oe_n_q;
  logic [3:0]            we_n_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [31:0]           wdata_q;
  logic [RD_LAT_W-1:0]   cnt_q;
  logic [3:0]            mask_q;
  logic [31:0]           hold_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [31:0]           rdata_q;
  logic                  rd_valid_q;
  logic                  wr_done_q;
  logic                  proto_err_q;
  logic [7:0]            wr_count_q;
  logic [31:0]           mem_q [DEPTH];

  logic [3:0]            lanes;
  logic [3:0]            mask_acc;
  logic [31:0]           hold_acc;
  logic [ADDR_W-1:0]     wr_addr_acc;
  logic [31:0]           commit_word;
  logic                  proto_hit;

  // Strobes are registered first; the FSM only ever looks at the sampled copies.
  always_ff @(posedge sys_clk1 or negedge n_sys_reset1) begin
    if (!n_sys_reset1) begin
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= '1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cs_n_q  <= smc_n_cs1;
      oe_n_q  <= smc_n_oe1;
      we_n_q  <= smc_n_we1;
      addr_q  <= smc_addr1;
      wdata_q <= smc_wdata1;
    end
  end

  // This cycle's lanes folded into the accumulated write, so a commit also
  // covers lanes strobed in the same cycle that chip select drops.
  always_comb begin
    lanes       = ~we_n_q;
    proto_hit   = !oe_n_q && (we_n_q != 4'hF);
    mask_acc    = mask_q | lanes;
    hold_acc    = hold_q;
    wr_addr_acc = wr_addr_q;
    if (lanes != '0) wr_addr_acc = addr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lanes[i]) hold_acc[8*i +: 8] = wdata_q[8*i +: 8];
    end
    commit_word = mem_q[wr_addr_acc];
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask_acc[i]) commit_word[8*i +: 8] = hold_acc[8*i +: 8];
    end
  end

  always_ff @(posedge sys_clk1 or negedge n_sys_reset1) begin
    if (!n_sys_reset1) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      hold_q      <= '0;
      wr_addr_q   <= '0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      proto_err_q <= 1'b0;
      wr_count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      proto_err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (!cs_n_q) state_q <= SEL;
      end else if (cs_n_q) begin
        if (state_q == WR) begin
          mem_q[wr_addr_acc] <= commit_word;
          wr_done_q          <= 1'b1;
          wr_count_q         <= wr_count_q + 8'd1;
        end
        mask_q  <= '0;
        state_q <= IDLE;
      end else if (proto_hit) begin
        proto_err_q <= 1'b1;
        mask_q      <= '0;
        state_q     <= SEL;
      end else begin
        case (state_q)
          SEL: begin
            if (!oe_n_q) begin
              // Zero latency skips the wait state so data is valid one cycle after SEL.
              if (rd_latency1 == '0) begin
                state_q    <= RD_DRV;
                rd_valid_q <= 1'b1;
                rdata_q    <= mem_q[smc_addr1];
              end else begin
                state_q <= RD_WAIT;
                cnt_q   <= rd_latency1 - 1'b1;
              end
            end else if (we_n_q != 4'hF) begin
              state_q   <= WR;
              mask_q    <= mask_acc;
              hold_q    <= hold_acc;
              wr_addr_q <= wr_addr_acc;
            end
          end
          RD_WAIT: begin
            if (oe_n_q) begin
              state_q <= SEL;
            end else if (cnt_q == '0) begin
              state_q    <= RD_DRV;
              rd_valid_q <= 1'b1;
              rdata_q    <= mem_q[smc_addr1];
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          RD_DRV: begin
            if (oe_n_q) begin
              state_q <= SEL;
            end else begin
              rd_valid_q <= 1'b1;
              rdata_q    <= mem_q[smc_addr1];
            end
          end
          WR: begin
            if (we_n_q == 4'hF) begin
              mem_q[wr_addr_acc] <= commit_word;
              wr_done_q          <= 1'b1;
              wr_count_q         <= wr_count_q + 8'd1;
              mask_q             <= '0;
              state_q            <= SEL;
            end else begin
              mask_q    <= mask_acc;
              hold_q    <= hold_acc;
              wr_addr_q <= wr_addr_acc;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign smc_rdata1 = rdata_q;
  assign rd_valid1  = rd_valid_q;
  assign wr_done1   = wr_done_q;
  assign proto_err1 = proto_err_q;
  assign wr_count1  = wr_count_q;

endmodule
